// File: rtl/mem_ctrl_if.sv
// Core-side bus of mem_ctrl: burst request, write-beat stream and read-response stream.
interface mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              done;

  modport master (
    output req_valid, req_rw, req_addr, req_len, wr_valid, wr_data,
    input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, wr_valid, wr_data,
    output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done
  );
endinterface

// File: rtl/mem_ctrl.sv
// Burst memory access controller: sequences 1-16 word reads/writes at wrapping
// addresses toward a single-port RAM and streams read data back to the core.
module mem_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         core,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_BEAT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q, k_d, len_q;
  logic [ADDR_W-1:0]   start_q, cur_addr, last_addr_q;
  logic [DATA_W-1:0]   last_wdata_q, rsp_data_q;
  logic [RD_LAT-1:0]   vld_q, lst_q;
  logic                armed_q, accept, req_ready, wr_ready, wr_last;
  logic                rd_issue, rd_done, done_wr_q, rsp_valid_q, rsp_last_q;

  // armed_q keeps req_ready low during reset and until the first edge after release
  assign req_ready = armed_q && (state_q == IDLE);
  assign accept    = core.req_valid && req_ready;
  assign cur_addr  = (start_q + ADDR_W'(k_q)) & ADDR_MASK;
  assign rd_issue  = mem_en && mem_rw;
  assign rd_done   = (state_q == RD_DRAIN) && rsp_valid_q && rsp_last_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mem_en   = 1'b0;
    mem_rw   = 1'b1;
    wr_ready = 1'b0;
    wr_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          k_d     = '0;
          state_d = core.req_rw ? RD_ISSUE : WR_BEAT;
        end
      end
      RD_ISSUE: begin
        mem_en = 1'b1;
        k_d    = k_q + 4'd1;
        if (k_q == len_q) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (rd_done) state_d = IDLE;
      end
      WR_BEAT: begin
        wr_ready = 1'b1;
        if (core.wr_valid) begin
          mem_en = 1'b1;
          mem_rw = 1'b0;
          k_d    = k_q + 4'd1;
          if (k_q == len_q) begin
            wr_last = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = mem_en ? cur_addr : last_addr_q;
  assign mem_wdata = (mem_en && !mem_rw) ? core.wr_data : last_wdata_q;

  assign core.req_ready = req_ready;
  assign core.wr_ready  = wr_ready;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_data  = rsp_data_q;
  assign core.rsp_last  = rsp_last_q;
  assign core.done      = done_wr_q || rd_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      len_q        <= '0;
      start_q      <= '0;
      armed_q      <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      done_wr_q    <= 1'b0;
      vld_q        <= '0;
      lst_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      armed_q   <= 1'b1;
      done_wr_q <= wr_last;
      if (accept) begin
        start_q <= core.req_addr;
        len_q   <= core.req_len;
      end
      if (mem_en) last_addr_q <= mem_addr;
      if (mem_en && !mem_rw) last_wdata_q <= mem_wdata;
      // Outstanding-read tracker: one bit per issued read, tail aligns with mem_q valid
      vld_q       <= RD_LAT'({vld_q, rd_issue});
      lst_q       <= RD_LAT'({lst_q, rd_issue && (k_q == len_q)});
      rsp_valid_q <= vld_q[RD_LAT-1];
      rsp_last_q  <= lst_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) rsp_data_q <= mem_q;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl with a behavioural RAM and a word-array
// reference model; monitors check memory commands, read beats and done pulses by cycle.
module tb_mem_ctrl;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 256;
  localparam int RD_LAT    = 4;
  localparam int AW        = $clog2(MEM_DEPTH);

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } cmd_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  logic              mem_en, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_q;

  logic [DATA_W-1:0] ram     [MEM_DEPTH];
  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  logic [DATA_W-1:0] qpipe   [RD_LAT];

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   done_q[$];
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [DATA_W-1:0] hold_wdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .core(bus),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  // Single-port RAM: read data appears RD_LAT cycles after the command cycle
  always @(posedge clk) begin
    if (mem_en && mem_rw) qpipe[0] <= ram[mem_addr[AW-1:0]];
    else                  qpipe[0] <= '1;
    for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
    if (mem_en && !mem_rw) ram[mem_addr[AW-1:0]] = mem_wdata;
  end
  assign mem_q = qpipe[RD_LAT-1];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitors: compare every DUT output event against the head of its expectation queue
  always @(negedge clk) begin : mon
    cmd_t ce;
    rsp_t re;
    int   de;
    while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
      chk("mem_en for expected beat", 0, 1);
      void'(cmd_q.pop_front());
    end
    if (mem_en) begin
      if (cmd_q.size() == 0) chk("unexpected mem_en", 1, 0);
      else begin
        ce = cmd_q.pop_front();
        chk("mem cmd cycle", cyc, ce.cyc);
        chk("mem_rw", mem_rw, ce.rw);
        chk("mem_addr", mem_addr, ce.addr);
        if (!ce.rw) begin
          chk("mem_wdata", mem_wdata, ce.data);
          hold_wdata = ce.data;
        end
        hold_addr = ce.addr;
      end
    end else begin
      chk("idle mem_rw", mem_rw, 1);
      chk("idle mem_addr hold", mem_addr, hold_addr);
      chk("idle mem_wdata hold", mem_wdata, hold_wdata);
    end

    while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
      chk("rsp_valid for expected beat", 0, 1);
      void'(rsp_q.pop_front());
    end
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected rsp_valid", 1, 0);
      else begin
        re = rsp_q.pop_front();
        chk("rsp cycle", cyc, re.cyc);
        chk("rsp_data", bus.rsp_data, re.data);
        chk("rsp_last", bus.rsp_last, re.last);
      end
    end else if (bus.rsp_last) begin
      chk("rsp_last without rsp_valid", 1, 0);
    end

    while (done_q.size() > 0 && done_q[0] < cyc) begin
      chk("done for expected burst", 0, 1);
      void'(done_q.pop_front());
    end
    if (bus.done) begin
      if (done_q.size() == 0) chk("unexpected done", 1, 0);
      else begin
        de = done_q.pop_front();
        chk("done cycle", cyc, de);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("reset req_ready", bus.req_ready, 0);
    chk("reset wr_ready", bus.wr_ready, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_last", bus.rsp_last, 0);
    chk("reset done", bus.done, 0);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_rw", mem_rw, 1);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rsp_data", bus.rsp_data, 0);
  endtask

  // Called at posedge+1; asserts rst mid-cycle and checks outputs before any edge
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    done_q.delete();
    hold_addr  = '0;
    hold_wdata = '0;
    #1;
    check_reset_vals();
    step();
    step();
  endtask

  task automatic release_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("req_ready before first edge", bus.req_ready, 0);
    step();
    chk("req_ready after release", bus.req_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk) chk("idle req_ready", bus.req_ready, 1);
      step();
    end
  endtask

  task automatic wait_busy(input int n);
    repeat (n) begin
      @(negedge clk) chk("busy req_ready", bus.req_ready, 0);
      step();
    end
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] addr, input logic [3:0] len);
    int t, idx;
    t = cyc;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    for (int k = 0; k <= int'(len); k++) begin
      idx = (int'(addr) + k) % MEM_DEPTH;
      cmd_q.push_back('{1'b1, ADDR_W'(idx), DATA_W'(0), t + 1 + k});
      rsp_q.push_back('{ref_mem[idx], (k == int'(len)), t + 2 + k + RD_LAT});
    end
    done_q.push_back(t + 2 + int'(len) + RD_LAT);
    @(negedge clk) chk("req_ready at read accept", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [3:0] len);
    issue_read(addr, len);
    wait_busy(int'(len) + RD_LAT + 2);
  endtask

  task automatic issue_write(input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                             input logic [DATA_W-1:0] base, input bit seq,
                             input int stall_at, input int stall_n);
    int idx;
    logic [DATA_W-1:0] d;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(negedge clk) chk("req_ready at write accept", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        repeat (stall_n) begin
          bus.wr_valid = 1'b0;
          bus.wr_data  = DATA_W'($urandom);
          @(negedge clk) chk("wr_ready during stall", bus.wr_ready, 1);
          step();
        end
      end
      d   = seq ? base + DATA_W'(i) : DATA_W'($urandom);
      idx = (int'(addr) + i) % MEM_DEPTH;
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      cmd_q.push_back('{1'b0, ADDR_W'(idx), d, cyc});
      ref_mem[idx] = d;
      @(negedge clk) chk("wr_ready on beat", bus.wr_ready, 1);
      step();
    end
    bus.wr_valid = 1'b0;
    done_q.push_back(cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [DATA_W-1:0] v;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      v = DATA_W'($urandom);
      ram[i]     = v;
      ref_mem[i] = v;
    end

    step();
    step();
    check_reset_vals();
    release_reset();

    issue_write(16'h0010, 4'd0, 16'hBEEF, 1'b1, 99, 0);
    read_burst(16'h0010, 4'd0);

    issue_write(16'h00FE, 4'd3, 16'h0001, 1'b1, 99, 0);
    read_burst(16'h00FE, 4'd3);

    // Upper address bits are ignored; three-cycle wr_valid gap mid-burst
    issue_write(16'h1234, 4'd7, '0, 1'b0, 3, 3);
    read_burst(16'h1234, 4'd7);

    // Request held valid through a 16-beat read must be taken exactly once
    issue_read(16'h0040, 4'd15);
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = 16'h00F8;
    bus.req_len   = 4'd9;
    wait_busy(15 + RD_LAT + 2);
    read_burst(16'h00F8, 4'd9);

    // Reset while beat 5 of a 16-beat read is being issued
    issue_read(16'h0030, 4'd15);
    repeat (5) step();
    apply_reset();
    release_reset();
    idle(RD_LAT + 6);
    read_burst(16'h0030, 4'd15);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] len;
      len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        read_burst(ADDR_W'($urandom), len);
      else
        issue_write(ADDR_W'($urandom), len, '0, 1'b0,
                    $urandom_range(0, int'(len) + 3), $urandom_range(1, 3));
      idle($urandom_range(0, 2));
    end

    idle(RD_LAT + 4);
    chk("pending mem commands", cmd_q.size(), 0);
    chk("pending read beats", rsp_q.size(), 0);
    chk("pending done pulses", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
